warp_decode_queue: RTL and testbench

- Multi-warp decode stage. Accepts fetched instructions tagged with a warp ID over a valid/ready handshake.
- Decodes each instruction into a control/immediate bundle and writes it into a per-warp FIFO.
- A round-robin issue arbiter presents one decoded bundle per cycle to the operand-fetch/execute stage.
- Sits between the fetcher and the register-file/ALU stage; replaces per-warp decode registers gated by WARP_DECODE.

---
 rtl/common_pkg.sv | 95 +++++++++
 rtl/decode_fields.sv | 103 ++++++++++
 rtl/warp_decode_queue.sv | 172 +++++++++++++++++
 tb/tb_warp_decode_queue.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared decode encodings for the warp decode queue: opcodes, ALU/branch codes,
// immediate selects and the decoded bundle layout.
package common_pkg;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011
  } opcode_t;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [1:0] BRJ_NONE = 2'd0;
  localparam logic [1:0] BRJ_BR   = 2'd1;
  localparam logic [1:0] BRJ_JAL  = 2'd2;
  localparam logic [1:0] BRJ_JALR = 2'd3;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_sel_t;

  typedef struct packed {
    logic        Scalar;
    logic        LdReg;
    logic [1:0]  IsBR_J;
    logic        DMemEN;
    logic [1:0]  DataSize;
    logic        DMemR_W;
    logic        Usign;
    logic        RS1Mux;
    logic [2:0]  BR;
    logic [3:0]  ALUK;
    logic        RS2Mux;
    logic        Finish;
    logic        Illegal;
    logic [4:0]  RS1Addr;
    logic [4:0]  RS2Addr;
    logic [4:0]  RDAddr;
    logic [31:0] IMM;
  } dec_bundle_t;

  localparam int DEC_W = $bits(dec_bundle_t);

  function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_sel_t sel);
    logic [31:0] imm;
    case (sel)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'h000};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'h0000_0000;
    endcase
    return imm;
  endfunction

  // alt selects SUB/SRA; callers mask it for immediates where bit 30 is data
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_fields.sv
// Purely combinational instruction -> dec_bundle_t decoder.
// Optional DEC_ILLEGAL_EN flags and neutralises unknown opcodes.
module decode_fields
  import common_pkg::*;
(
  input  logic [31:0] i_instr,
  output dec_bundle_t o_dec
);

  opcode_t     w_opc;
  logic [2:0]  w_f3;
  logic        w_alt;
  imm_sel_t    w_sel;
  dec_bundle_t w_d;

  assign w_opc = opcode_t'(i_instr[6:0]);
  assign w_f3  = i_instr[14:12];
  assign w_alt = i_instr[30];

  // Field decode; defaults describe a register-writing ADD with immediate operand
  always_comb begin
    w_d         = '0;
    w_sel       = IMM_NONE;
    w_d.LdReg   = 1'b1;
    w_d.RS2Mux  = 1'b1;
    w_d.ALUK    = ALU_ADD;
    w_d.Finish  = (i_instr == 32'h0000_0000);
    w_d.RS1Addr = i_instr[19:15];
    w_d.RS2Addr = i_instr[24:20];
    w_d.RDAddr  = i_instr[11:7];
    case (w_opc)
      OP_LUI: begin
        w_d.Scalar = 1'b1;
        w_d.ALUK   = ALU_PASSB;
        w_sel      = IMM_U;
      end
      OP_AUIPC: begin
        w_d.Scalar = 1'b1;
        w_d.RS1Mux = 1'b1;
        w_sel      = IMM_U;
      end
      OP_JAL: begin
        w_d.Scalar = 1'b1;
        w_d.RS1Mux = 1'b1;
        w_d.IsBR_J = BRJ_JAL;
        w_sel      = IMM_J;
      end
      OP_JALR: begin
        w_d.IsBR_J = BRJ_JALR;
        w_sel      = IMM_I;
      end
      OP_BRANCH: begin
        w_d.LdReg  = 1'b0;
        w_d.IsBR_J = BRJ_BR;
        w_d.BR     = w_f3;
        w_d.Usign  = w_f3[1];
        w_d.RS2Mux = 1'b0;
        w_d.ALUK   = ALU_SUB;
        w_sel      = IMM_B;
      end
      OP_LOAD: begin
        w_d.DMemEN   = 1'b1;
        w_d.DataSize = w_f3[1:0];
        w_d.Usign    = w_f3[2];
        w_sel        = IMM_I;
      end
      OP_STORE: begin
        w_d.LdReg    = 1'b0;
        w_d.DMemEN   = 1'b1;
        w_d.DMemR_W  = 1'b1;
        w_d.DataSize = w_f3[1:0];
        w_sel        = IMM_S;
      end
      OP_IMM: begin
        w_d.ALUK = alu_op(w_f3, w_alt && (w_f3 == 3'b101));
        w_sel    = IMM_I;
      end
      OP_REG: begin
        w_d.RS2Mux = 1'b0;
        w_d.ALUK   = alu_op(w_f3, w_alt);
      end
      default: begin
`ifdef DEC_ILLEGAL_EN
        // the all-zero Finish word is a legitimate terminator, not illegal
        if (!w_d.Finish) begin
          w_d.Illegal = 1'b1;
          w_d.LdReg   = 1'b0;
          w_d.DMemEN  = 1'b0;
          w_d.IsBR_J  = BRJ_NONE;
        end else begin
          w_d.Illegal = 1'b0;
        end
`else
        w_d.Illegal = 1'b0;
`endif
      end
    endcase
    w_d.IMM = imm_gen(i_instr, w_sel);
  end

  assign o_dec = w_d;

endmodule

// File: rtl/warp_decode_queue.sv
// Multi-warp decode stage: decode, per-warp FIFOs, round-robin issue, flush/halt.
// Optional macro DEC_ILLEGAL_EN enables illegal-opcode flagging and illegal_pulse.
module warp_decode_queue
  import common_pkg::*;
#(
  parameter  int NUM_WARPS = 4,
  parameter  int DEPTH     = 4,
  localparam int WID_W     = $clog2(NUM_WARPS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WID_W-1:0]     in_warp,
  input  logic [31:0]          in_instr,
  input  logic [NUM_WARPS-1:0] warp_issue_en,
  input  logic                 flush_valid,
  input  logic [WID_W-1:0]     flush_warp,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WID_W-1:0]     out_warp,
  output logic [DEC_W-1:0]     out_dec,
  output logic [NUM_WARPS-1:0] halted,
  output logic                 illegal_pulse
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  dec_bundle_t          r_mem    [NUM_WARPS][DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr [NUM_WARPS];
  logic [PTR_W-1:0]     r_rd_ptr [NUM_WARPS];
  logic [CNT_W-1:0]     r_count  [NUM_WARPS];
  logic [NUM_WARPS-1:0] r_halted;
  logic [WID_W-1:0]     r_rr;

  dec_bundle_t          w_dec;
  logic [NUM_WARPS-1:0] w_full;
  logic [NUM_WARPS-1:0] w_flush;
  logic [NUM_WARPS-1:0] w_elig;
  logic [NUM_WARPS-1:0] w_push_v;
  logic [NUM_WARPS-1:0] w_pop_v;
  logic [WID_W:0]       w_sum;
  logic [WID_W-1:0]     w_idx;
  logic [WID_W-1:0]     w_win;
  logic [WID_W-1:0]     w_rr_next;
  logic                 w_found;
  logic                 w_push;
  logic                 w_pop;

  decode_fields u_decode_fields (
    .i_instr (in_instr),
    .o_dec   (w_dec)
  );

  // Per-warp status: full, flush target, issue eligibility (flush target excluded)
  always_comb begin
    w_full  = '0;
    w_flush = '0;
    w_elig  = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      w_full[w]  = (r_count[w] == CNT_W'(DEPTH));
      w_flush[w] = flush_valid && (flush_warp == WID_W'(w));
      w_elig[w]  = (r_count[w] != '0) && warp_issue_en[w] && !w_flush[w];
    end
  end

  assign in_ready = !w_full[in_warp] && !r_halted[in_warp] && !w_flush[in_warp];
  assign w_push   = in_valid && in_ready;

  // Round-robin search: first eligible warp at or after r_rr, wrapping
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      w_sum = {1'b0, r_rr} + (WID_W+1)'(i);
      w_idx = (w_sum >= (WID_W+1)'(NUM_WARPS)) ? WID_W'(w_sum - (WID_W+1)'(NUM_WARPS))
                                               : w_sum[WID_W-1:0];
      w_win   = (w_found || !w_elig[w_idx]) ? w_win : w_idx;
      w_found = w_found || w_elig[w_idx];
    end
  end

  assign w_pop     = w_found && out_ready;
  assign w_rr_next = (w_win == WID_W'(NUM_WARPS-1)) ? '0 : w_win + WID_W'(1);
  assign out_valid = w_found;
  assign out_warp  = w_found ? w_win : '0;
  assign out_dec   = w_found ? r_mem[w_win][r_rd_ptr[w_win]] : '0;
  assign halted    = r_halted;

  // Per-warp push/pop strobes
  always_comb begin
    w_push_v = '0;
    w_pop_v  = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      w_push_v[w] = w_push && (in_warp == WID_W'(w));
      w_pop_v[w]  = w_pop && (w_win == WID_W'(w));
    end
  end

  // FIFO pointers, occupancy and halt flags; flush wins over push/pop of its warp
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        r_wr_ptr[w] <= '0;
        r_rd_ptr[w] <= '0;
        r_count[w]  <= '0;
      end
      r_halted <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (w_flush[w]) begin
          r_wr_ptr[w] <= '0;
          r_rd_ptr[w] <= '0;
          r_count[w]  <= '0;
          r_halted[w] <= 1'b0;
        end else begin
          if (w_push_v[w]) begin
            r_wr_ptr[w] <= r_wr_ptr[w] + PTR_W'(1);
            if (w_dec.Finish) begin
              r_halted[w] <= 1'b1;
            end
          end
          if (w_pop_v[w]) begin
            r_rd_ptr[w] <= r_rd_ptr[w] + PTR_W'(1);
          end
          case ({w_push_v[w], w_pop_v[w]})
            2'b10:   r_count[w] <= r_count[w] + CNT_W'(1);
            2'b01:   r_count[w] <= r_count[w] - CNT_W'(1);
            default: r_count[w] <= r_count[w];
          endcase
        end
      end
    end
  end

  // Entry storage; contents are only observed through valid head pointers
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[in_warp][r_wr_ptr[in_warp]] <= w_dec;
    end
  end

  // Round-robin pointer advances only on an actual issue
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr <= '0;
    end else if (w_pop) begin
      r_rr <= w_rr_next;
    end
  end

`ifdef DEC_ILLEGAL_EN
  logic r_illegal;

  // One-cycle flag for an accepted illegal instruction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= w_push && w_dec.Illegal;
    end
  end

  assign illegal_pulse = r_illegal;
`else
  assign illegal_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_warp_decode_queue.sv
// Directed self-checking bench for warp_decode_queue (NUM_WARPS=4, DEPTH=4).
module tb_warp_decode_queue;
  import common_pkg::*;

`ifdef DEC_ILLEGAL_EN
  localparam logic ILL_EN = 1'b1;
`else
  localparam logic ILL_EN = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_warp;
  logic [31:0]      in_instr;
  logic [3:0]       warp_issue_en;
  logic             flush_valid;
  logic [1:0]       flush_warp;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_warp;
  logic [DEC_W-1:0] out_dec;
  logic [3:0]       halted;
  logic             illegal_pulse;
  dec_bundle_t      d;
  int               errors;
  int               checks;

  assign d = dec_bundle_t'(out_dec);

  warp_decode_queue #(.NUM_WARPS(4), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_warp(in_warp), .in_instr(in_instr), .warp_issue_en(warp_issue_en),
    .flush_valid(flush_valid), .flush_warp(flush_warp), .out_valid(out_valid),
    .out_ready(out_ready), .out_warp(out_warp), .out_dec(out_dec),
    .halted(halted), .illegal_pulse(illegal_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ADDI x<rd>, x0, <rd>
  function automatic logic [31:0] addi(input int rd);
    return (32'(rd) << 20) | (32'(rd) << 7) | 32'h0000_0013;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_warp = 2'd0; in_instr = 32'h0; out_ready = 1'b0;
    flush_valid = 1'b0; flush_warp = 2'd0; warp_issue_en = 4'hF;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%0h exp=0", out_valid); end
    checks++; if (halted !== 4'h0) begin errors++; $display("FAIL rst_halted got=%0h exp=0", halted); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%0h exp=1", in_ready); end
    checks++; if (out_dec !== '0) begin errors++; $display("FAIL rst_out_dec got=%0h exp=0", out_dec); end
    checks++; if (illegal_pulse !== 1'b0) begin errors++; $display("FAIL rst_illegal got=%0h exp=0", illegal_pulse); end
    reset = 1'b1;
    tick();
    in_valid = 1'b1; in_warp = 2'd1;
    for (int k = 0; k < 3; k++) begin
      in_instr = addi(k + 1);
      tick();
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid got=%0h exp=1", out_valid); end
    #2 reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%0h exp=0", out_valid); end
    checks++; if (halted !== 4'h0) begin errors++; $display("FAIL midrst_halted got=%0h exp=0", halted); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got=%0h exp=1", in_ready); end
    reset = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_empty got=%0h exp=0", out_valid); end
  endtask

  task automatic test_add();
    out_ready = 1'b1; in_valid = 1'b1; in_warp = 2'd2; in_instr = 32'h0020_81B3;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_no_bypass got=%0h exp=0", out_valid); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%0h exp=1", out_valid); end
    checks++; if (out_warp !== 2'd2) begin errors++; $display("FAIL add_warp got=%0h exp=2", out_warp); end
    checks++; if (d.ALUK !== 4'd0) begin errors++; $display("FAIL add_aluk got=%0h exp=0", d.ALUK); end
    checks++; if (d.RS2Mux !== 1'b0) begin errors++; $display("FAIL add_rs2mux got=%0h exp=0", d.RS2Mux); end
    checks++; if (d.RDAddr !== 5'd3) begin errors++; $display("FAIL add_rd got=%0h exp=3", d.RDAddr); end
    checks++; if ({d.RS1Addr, d.RS2Addr} !== {5'd1, 5'd2}) begin errors++; $display("FAIL add_rs got=%0h exp=22", {d.RS1Addr, d.RS2Addr}); end
    checks++; if (d.LdReg !== 1'b1) begin errors++; $display("FAIL add_ldreg got=%0h exp=1", d.LdReg); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_popped got=%0h exp=0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_load_store();
    in_valid = 1'b1; in_warp = 2'd0; in_instr = 32'h0081_2283;   // lw x5, 8(x2)
    tick();
    in_instr = 32'h0051_2623;                                     // sw x5, 12(x2)
    tick();
    in_valid = 1'b0;
    checks++; if ({d.DMemEN, d.DMemR_W, d.LdReg, d.DataSize} !== 5'b10110) begin errors++; $display("FAIL lw_ctl got=%0h exp=16", {d.DMemEN, d.DMemR_W, d.LdReg, d.DataSize}); end
    checks++; if (d.IMM !== 32'd8) begin errors++; $display("FAIL lw_imm got=%0h exp=8", d.IMM); end
    out_ready = 1'b1;
    tick();
    checks++; if ({d.DMemEN, d.DMemR_W, d.LdReg, d.DataSize} !== 5'b11010) begin errors++; $display("FAIL sw_ctl got=%0h exp=1a", {d.DMemEN, d.DMemR_W, d.LdReg, d.DataSize}); end
    checks++; if (d.IMM !== 32'd12) begin errors++; $display("FAIL sw_imm got=%0h exp=c", d.IMM); end
    checks++; if (d.RS2Mux !== 1'b1) begin errors++; $display("FAIL sw_rs2mux got=%0h exp=1", d.RS2Mux); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ls_drained got=%0h exp=0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_full();
    in_valid = 1'b1; in_warp = 2'd0;
    for (int k = 0; k < 4; k++) begin
      in_instr = addi(k + 1);
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready_w0 got=%0h exp=0", in_ready); end
    in_warp = 2'd1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_w1 got=%0h exp=1", in_ready); end
    in_warp = 2'd0; in_valid = 1'b1; in_instr = addi(9); out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_pop_refuse got=%0h exp=0", in_ready); end
    checks++; if (d.RDAddr !== 5'd1) begin errors++; $display("FAIL full_head0 got=%0h exp=1", d.RDAddr); end
    tick();
    in_instr = addi(5);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_after_pop got=%0h exp=1", in_ready); end
    checks++; if (d.RDAddr !== 5'd2) begin errors++; $display("FAIL full_head1 got=%0h exp=2", d.RDAddr); end
    tick();
    out_ready = 1'b0; in_instr = addi(6);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pushpop_count got=%0h exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL refill_full got=%0h exp=0", in_ready); end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (d.RDAddr !== 5'(k + 3)) begin errors++; $display("FAIL drain_order[%0d] got=%0d exp=%0d", k, d.RDAddr, k + 3); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%0h exp=0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [1:0] seq [6];
    seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd3; seq[3] = 2'd0; seq[4] = 2'd1; seq[5] = 2'd3;
    reset = 1'b0;
    #2 reset = 1'b1;
    tick();
    in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 4; w++) begin
        in_warp = 2'(w); in_instr = addi(w * 4 + k + 1);
        tick();
      end
    end
    in_valid = 1'b0; warp_issue_en = 4'b1011; out_ready = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      checks++; if ({out_valid, out_warp} !== {1'b1, seq[i]}) begin errors++; $display("FAIL rr_warp[%0d] got=%0h exp=%0h", i, {out_valid, out_warp}, {1'b1, seq[i]}); end
      checks++; if (d.RDAddr !== 5'(seq[i] * 4 + i / 3 + 1)) begin errors++; $display("FAIL rr_rd[%0d] got=%0d exp=%0d", i, d.RDAddr, seq[i] * 4 + i / 3 + 1); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_w2_masked got=%0h exp=0", out_valid); end
    warp_issue_en = 4'hF;
    #1;
    checks++; if ({out_valid, out_warp, d.RDAddr} !== {1'b1, 2'd2, 5'd9}) begin errors++; $display("FAIL rr_w2_enabled got=%0h exp=%0h", {out_valid, out_warp, d.RDAddr}, {1'b1, 2'd2, 5'd9}); end
    tick();
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_finish_flush();
    in_valid = 1'b1; in_warp = 2'd1; in_instr = 32'h0020_81B3;
    tick();
    in_instr = 32'h0000_0000;
    tick();
    checks++; if (halted !== 4'b0010) begin errors++; $display("FAIL fin_halted got=%0h exp=2", halted); end
    checks++; if (illegal_pulse !== 1'b0) begin errors++; $display("FAIL fin_no_illegal got=%0h exp=0", illegal_pulse); end
    in_warp = 2'd3; in_instr = addi(7);
    tick();
    in_warp = 2'd1; in_instr = addi(8);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fin_refuse got=%0h exp=0", in_ready); end
    tick();
    in_valid = 1'b0; flush_valid = 1'b1; flush_warp = 2'd1; out_ready = 1'b1; warp_issue_en = 4'b0111;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_suppress got=%0h exp=0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%0h exp=0", in_ready); end
    tick();
    flush_valid = 1'b0;
    #1;
    checks++; if (halted !== 4'h0) begin errors++; $display("FAIL flush_halted got=%0h exp=0", halted); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got=%0h exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got=%0h exp=0", out_valid); end
    warp_issue_en = 4'hF;
    #1;
    checks++; if ({out_valid, out_warp, d.RDAddr} !== {1'b1, 2'd3, 5'd7}) begin errors++; $display("FAIL flush_other got=%0h exp=%0h", {out_valid, out_warp, d.RDAddr}, {1'b1, 2'd3, 5'd7}); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_done got=%0h exp=0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_illegal();
    in_valid = 1'b1; in_warp = 2'd2; in_instr = 32'h0000_018B;
    tick();
    in_valid = 1'b0;
    checks++; if (illegal_pulse !== ILL_EN) begin errors++; $display("FAIL ill_pulse got=%0h exp=%0h", illegal_pulse, ILL_EN); end
    checks++; if (d.Illegal !== ILL_EN) begin errors++; $display("FAIL ill_flag got=%0h exp=%0h", d.Illegal, ILL_EN); end
    checks++; if ({d.LdReg, d.DMemEN, d.IsBR_J} !== {!ILL_EN, 3'b000}) begin errors++; $display("FAIL ill_ctl got=%0h exp=%0h", {d.LdReg, d.DMemEN, d.IsBR_J}, {!ILL_EN, 3'b000}); end
    checks++; if ({d.ALUK, d.RS2Mux, d.RDAddr} !== {4'd0, 1'b1, 5'd3}) begin errors++; $display("FAIL ill_fields got=%0h exp=%0h", {d.ALUK, d.RS2Mux, d.RDAddr}, {4'd0, 1'b1, 5'd3}); end
    tick();
    checks++; if (illegal_pulse !== 1'b0) begin errors++; $display("FAIL ill_one_cycle got=%0h exp=0", illegal_pulse); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ill_drained got=%0h exp=0", out_valid); end
    out_ready = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_add();
    test_load_store();
    test_full();
    test_round_robin();
    test_finish_flush();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
